// File: rtl/add_pkg.sv
// Shared types and defaults for the adder bus controller and its settle counter.
package add_pkg;

    localparam int ADD_WIDTH  = 32;
    localparam int ADD_SETTLE = 2;
    localparam int ADD_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CAPTURE,
        RESP
    } add_state_t;

endpackage

// File: rtl/add_settle_cnt.sv
// Loadable down-counter with a zero flag, used to time the adder ripple-settle window.
module add_settle_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/add_bus_ctrl.sv
// Initiator-side controller for the 32-bit ripple-carry adder bus.
// Define ADD_BUS_CTRL_CHECK_EN to add the rsp_err result self-check.
module add_bus_ctrl
    import add_pkg::*;
#(
    parameter int WIDTH  = ADD_WIDTH,
    parameter int SETTLE = ADD_SETTLE,
    parameter int CNT_W  = ADD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_ovf,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_en,
    input  logic [WIDTH-1:0] add_z
`ifdef ADD_BUS_CTRL_CHECK_EN
    ,
    output logic             rsp_err
`endif
);

    add_state_t state, state_next;
    logic       cnt_load, cnt_dec, cnt_zero;
    logic       accept, rsp_fire;

    assign accept   = (state == IDLE) && req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    add_settle_cnt #(.CNT_W(CNT_W)) u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .load_val(CNT_W'(SETTLE - 1)),
        .dec     (cnt_dec),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = DRIVE;
                    cnt_load   = 1'b1;
                end
            end
            DRIVE: begin
                if (cnt_zero) state_next = CAPTURE;
                else          cnt_dec    = 1'b1;
            end
            CAPTURE: state_next = RESP;
            RESP: begin
                if (rsp_fire) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Enable stays up through the capture cycle so add_z is still driven when sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_ovf   <= 1'b0;
            add_a     <= '0;
            add_b     <= '0;
            add_en    <= 1'b0;
`ifdef ADD_BUS_CTRL_CHECK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        add_a     <= req_a;
                        add_b     <= req_b;
                        add_en    <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end
                CAPTURE: begin
                    rsp_sum   <= add_z;
                    rsp_ovf   <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                                 (add_z[WIDTH-1] != add_a[WIDTH-1]);
                    add_en    <= 1'b0;
                    rsp_valid <= 1'b1;
`ifdef ADD_BUS_CTRL_CHECK_EN
                    rsp_err   <= (add_z != WIDTH'(add_a + add_b));
`endif
                end
                RESP: begin
                    if (rsp_fire) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
`ifdef ADD_BUS_CTRL_CHECK_EN
                        rsp_err   <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_add_bus_ctrl.sv
// Randomized bench for add_bus_ctrl with a behavioural adder model on the bus.
// Covers the rsp_err check when ADD_BUS_CTRL_CHECK_EN is defined.
module tb_add_bus_ctrl;

    localparam int W      = 32;
    localparam int SETTLE = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_ovf;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_en;
    logic [W-1:0] add_z;
    logic         fault = 1'b0;
`ifdef ADD_BUS_CTRL_CHECK_EN
    logic         rsp_err;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Adder bus: drives its sum only while enabled, optionally off by one.
    assign add_z = add_en ? (add_a + add_b + {{(W-1){1'b0}}, fault}) : '0;

    add_bus_ctrl #(.WIDTH(W), .SETTLE(SETTLE), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_sum  (rsp_sum),
        .rsp_ovf  (rsp_ovf),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_en   (add_en),
        .add_z    (add_z)
`ifdef ADD_BUS_CTRL_CHECK_EN
        ,
        .rsp_err  (rsp_err)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Signed overflow from the true mathematical sum, or from the sign rule when the adder is faulty.
    function automatic logic modelOvf(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic flt);
        longint       s;
        logic [W-1:0] z;
        if (!flt) begin
            s = longint'($signed(a)) + longint'($signed(b));
            return (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
        end
        z = a + b + 1;
        return (a[W-1] == b[W-1]) && (z[W-1] != a[W-1]);
    endfunction

    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] exp_sum;
        int           cycles;
        int           en_cycles;
        exp_sum = a + b + (fault ? 32'd1 : 32'd0);
        checkOutput("req_ready_idle", req_ready, 1);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        cycles    = 0;
        en_cycles = 0;
        while (!rsp_valid && cycles < 20) begin
            if (add_en) en_cycles++;
            @(negedge clk);
            cycles++;
        end
        checkOutput("latency", cycles, SETTLE + 1);
        checkOutput("en_cycles", en_cycles, SETTLE + 1);
        checkOutput("rsp_sum", rsp_sum, exp_sum);
        checkOutput("rsp_ovf", rsp_ovf, modelOvf(a, b, fault));
        checkOutput("add_a_hold", add_a, a);
        checkOutput("add_b_hold", add_b, b);
`ifdef ADD_BUS_CTRL_CHECK_EN
        checkOutput("rsp_err", rsp_err, fault);
`endif
        for (int i = 0; i < hold; i++) begin
            checkOutput("bp_sum", rsp_sum, exp_sum);
            checkOutput("bp_valid", rsp_valid, 1);
            checkOutput("bp_req_ready", req_ready, 0);
            checkOutput("bp_en", add_en, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_done", rsp_valid, 0);
        checkOutput("req_ready_back", req_ready, 1);
    endtask

    // Enable must be low whenever the controller is idle or presenting a response.
    always @(negedge clk) begin
        if (!rst && (req_ready || rsp_valid)) checkOutput("en_outside", add_en, 0);
    end

    initial begin
        logic seen;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        checkOutput("rst_req_ready", req_ready, 1);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_sum", rsp_sum, 0);
        checkOutput("rst_rsp_ovf", rsp_ovf, 0);
        checkOutput("rst_add_a", add_a, 0);
        checkOutput("rst_add_b", add_b, 0);
        checkOutput("rst_add_en", add_en, 0);

        applyStimulus(32'h0000_0005, 32'h0000_0003, 0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 0);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 0);
        applyStimulus($urandom, $urandom, 10);

        // Reset while the operands are on the bus drops the transaction entirely.
        req_a     = 32'h1234_5678;
        req_b     = 32'h1111_1111;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("mid_en_before", add_en, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_add_en", add_en, 0);
        checkOutput("mid_req_ready", req_ready, 1);
        checkOutput("mid_rsp_valid", rsp_valid, 0);
        checkOutput("mid_rsp_sum", rsp_sum, 0);
        checkOutput("mid_add_a", add_a, 0);
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen = seen | rsp_valid;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        checkOutput("mid_no_rsp", seen, 0);

        for (int n = 0; n < 1000; n++) begin
            applyStimulus($urandom, $urandom, (n % 50 == 0) ? int'($urandom_range(1, 4)) : 0);
        end

`ifdef ADD_BUS_CTRL_CHECK_EN
        fault = 1'b1;
        for (int n = 0; n < 20; n++) applyStimulus($urandom, $urandom, 0);
        fault = 1'b0;
        for (int n = 0; n < 20; n++) applyStimulus($urandom, $urandom, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
